// File: rtl/burst_ram_model.sv
// burst_ram_model: cycle-accurate burst RAM (PSRAM controller plus device) on the br_* wiring
module burst_ram_model #(
  parameter int    DEPTH_BITWIDTH = 10,
  parameter int    BURST_BEATS    = 4,
  parameter int    READ_LATENCY   = 6,
  parameter int    WRITE_RECOVERY = 2,
  parameter int    INIT_CYCLES    = 16,
  parameter string INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      init_calib,
  output logic                      cmd_ready,
  input  logic                      br_cmd,
  input  logic                      br_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] br_addr,
  input  logic [63:0]               br_wr_data,
  input  logic [7:0]                br_data_mask,
  output logic [63:0]               br_rd_data,
  output logic                      br_rd_data_valid,
  output logic                      cmd_dropped
);
  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_WRITE = 3'd2,
                         S_READ_WAIT = 3'd3, S_READ = 3'd4, S_RECOVER = 3'd5;
  logic [2:0]                state;
  logic [31:0]               cnt;
  logic [DEPTH_BITWIDTH-1:0] addr, wa, ra;
  logic                      we;
  logic [63:0]               mem [2**DEPTH_BITWIDTH] = '{default: '0};
  assign cmd_ready = state == S_IDLE;
  assign we = !rst && ((cmd_ready && br_cmd_en && br_cmd) || state == S_WRITE);
  assign wa = cmd_ready ? br_addr : addr + cnt[DEPTH_BITWIDTH-1:0];
  assign ra = cmd_ready ? br_addr : state == S_READ_WAIT ? addr : addr + cnt[DEPTH_BITWIDTH-1:0];
  always_ff @(posedge clk)
    if (we)
      for (int b = 0; b < 8; b++)
        if (!br_data_mask[b]) mem[wa][8*b +: 8] <= br_wr_data[8*b +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_INIT;
      cnt              <= '0;
      addr             <= '0;
      init_calib       <= 1'b0;
      br_rd_data       <= '0;
      br_rd_data_valid <= 1'b0;
      cmd_dropped      <= 1'b0;
    end else begin
      cmd_dropped <= br_cmd_en && state != S_IDLE;
      case (state)
        S_INIT:
          if (cnt == INIT_CYCLES - 1) begin
            state      <= S_IDLE;
            cnt        <= '0;
            init_calib <= 1'b1;
          end else cnt <= cnt + 32'd1;
        S_IDLE:
          if (br_cmd_en) begin
            addr <= br_addr;
            if (br_cmd) begin
              state <= S_WRITE;
              cnt   <= 32'd1;
            end else if (READ_LATENCY == 1) begin
              state            <= S_READ;
              cnt              <= 32'd1;
              br_rd_data       <= mem[ra];
              br_rd_data_valid <= 1'b1;
            end else begin
              state <= S_READ_WAIT;
              cnt   <= '0;
            end
          end
        S_WRITE:
          if (cnt == BURST_BEATS - 1) begin
            state <= WRITE_RECOVERY > 0 ? S_RECOVER : S_IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 32'd1;
        S_READ_WAIT:
          if (cnt == READ_LATENCY - 2) begin
            state            <= S_READ;
            cnt              <= 32'd1;
            br_rd_data       <= mem[ra];
            br_rd_data_valid <= 1'b1;
          end else cnt <= cnt + 32'd1;
        S_READ:
          if (cnt == BURST_BEATS) begin
            state            <= S_IDLE;
            cnt              <= '0;
            br_rd_data_valid <= 1'b0;
          end else begin
            br_rd_data <= mem[ra];
            cnt        <= cnt + 32'd1;
          end
        S_RECOVER:
          if (cnt == WRITE_RECOVERY - 1) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else cnt <= cnt + 32'd1;
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_ram_model.sv
// tb_burst_ram_model: directed bench with a cycle-scheduled transaction model of burst_ram_model
module tb_burst_ram_model;
   localparam int L = 6, B = 4, WR = 2, IC = 16;
   logic        clk = 0, rst = 1, br_cmd = 0, br_cmd_en = 0;
   logic [9:0]  br_addr = '0;
   logic [63:0] br_wr_data = '0;
   logic [7:0]  br_data_mask = '0;
   logic        init_calib, cmd_ready, br_rd_data_valid, cmd_dropped;
   logic [63:0] br_rd_data;
   always #5 clk = ~clk;
   burst_ram_model #(.DEPTH_BITWIDTH(10), .BURST_BEATS(B), .READ_LATENCY(L),
                     .WRITE_RECOVERY(WR), .INIT_CYCLES(IC), .INIT_FILE("")) dut (
      .clk(clk), .rst(rst), .init_calib(init_calib), .cmd_ready(cmd_ready),
      .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
      .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
      .cmd_dropped(cmd_dropped));
   int          n_chk = 0, n_fail = 0, cyc = 0, wl = 0;
   int          ready_at = 1 << 30, calib_at = 1 << 30;
   bit          chk_on = 0;
   logic [9:0]  wa;
   logic [63:0] m [1024];
   logic [63:0] vbeat [int];
   logic [63:0] rd_evt [int];
   bit          drop [int];
   logic [63:0] exp_rd = '0;
   logic [63:0] got [$];
   int          ks [$];
   initial foreach (m[i]) m[i] = '0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask
   task automatic apply(input logic [9:0] a);
      for (int b = 0; b < 8; b++)
         if (!br_data_mask[b]) m[a][8*b +: 8] = br_wr_data[8*b +: 8];
   endtask
   // model: at the end of each cycle, turn that cycle's inputs into scheduled expectations
   always @(posedge clk) begin
      if (rst) begin
         chk_on   = 1;
         calib_at = cyc + 1 + IC;
         ready_at = calib_at;
         wl       = 0;
         ks = {};
         foreach (vbeat[k]) if (k > cyc) ks.push_back(k);
         foreach (ks[j]) begin
            vbeat.delete(ks[j]);
            rd_evt.delete(ks[j]);
         end
         rd_evt[cyc + 1] = '0;
      end else begin
         if (wl > 0) begin
            apply(wa);
            wa = wa + 10'd1;
            wl--;
         end
         if (br_cmd_en && cyc >= ready_at) begin
            if (br_cmd) begin
               apply(br_addr);
               wa       = br_addr + 10'd1;
               wl       = B - 1;
               ready_at = cyc + B + WR;
            end else begin
               for (int i = 0; i < B; i++) begin
                  vbeat[cyc + L + i]  = m[br_addr + 10'(i)];
                  rd_evt[cyc + L + i] = m[br_addr + 10'(i)];
               end
               ready_at = cyc + L + B;
            end
         end else if (br_cmd_en) drop[cyc + 1] = 1;
      end
      cyc++;
   end
   always @(negedge clk) begin
      if (br_rd_data_valid === 1'b1) got.push_back(br_rd_data);
      if (chk_on) begin
         if (rd_evt.exists(cyc)) exp_rd = rd_evt[cyc];
         chk("init_calib", 64'(init_calib), 64'(cyc >= calib_at));
         chk("cmd_ready", 64'(cmd_ready), 64'(cyc >= ready_at));
         chk("rd_valid", 64'(br_rd_data_valid), 64'(vbeat.exists(cyc)));
         chk("rd_data", br_rd_data, exp_rd);
         chk("cmd_dropped", 64'(cmd_dropped), 64'(drop.exists(cyc)));
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_ready;
      for (int g = 0; g < 300 && cyc < ready_at; g++) tick;
   endtask
   task automatic wr(input logic [9:0] a, input logic [63:0] d0, d1, d2, d3, input logic [7:0] m0);
      wait_ready;
      br_cmd_en = 1; br_cmd = 1; br_addr = a; br_wr_data = d0; br_data_mask = m0;
      tick;
      br_cmd_en = 0; br_addr = 10'($urandom); br_data_mask = '0; br_wr_data = d1;
      tick;
      br_wr_data = d2;
      tick;
      br_wr_data = d3;
      tick;
      br_wr_data = {$urandom, $urandom}; br_data_mask = 8'($urandom);
   endtask
   task automatic rd(input logic [9:0] a, output int base);
      wait_ready;
      base = got.size();
      br_cmd_en = 1; br_cmd = 0; br_addr = a;
      tick;
      br_cmd_en = 0;
      repeat (L + B) tick;
   endtask
   task automatic chk_burst(input string nm, input int base, input logic [63:0] e0, e1, e2, e3);
      logic [63:0] e [4];
      e = '{e0, e1, e2, e3};
      chk({nm, "_count"}, 64'(got.size() - base), 64'(B));
      for (int i = 0; i < B; i++) chk($sformatf("%s_beat%0d", nm, i), got[base + i], e[i]);
   endtask
   localparam logic [63:0] A = 64'hAAAA_0000_1234_5678, BB = 64'hBBBB_1111_8765_4321,
                           C = 64'hCCCC_2222_DEAD_BEEF, D = 64'hDDDD_3333_CAFE_F00D;
   initial begin
      int base;
      rst = 1;
      repeat (3) tick;
      rst = 0;
      tick;
      tick;
      br_cmd_en = 1; br_cmd = 0; br_addr = 10'h010;
      tick;
      br_cmd_en = 0;
      chk("init_drop", 64'(cmd_dropped), 64'd1);
      repeat (12) tick;
      chk("calib_low_at_15", 64'(init_calib), 64'd0);
      tick;
      chk("calib_high_at_16", 64'(init_calib), 64'd1);
      chk("init_no_beats", 64'(got.size()), 64'd0);
      wr(10'h010, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
         64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 8'h00);
      rd(10'h010, base);
      chk_burst("wr_rd", base, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      wr(10'h020, '1, '1, '1, '1, 8'h00);
      wr(10'h020, '0, '0, '0, '0, 8'hF0);
      rd(10'h020, base);
      chk_burst("mask", base, 64'hFFFF_FFFF_0000_0000, '0, '0, '0);
      wr(10'h3FE, A, BB, C, D, 8'h00);
      rd(10'h3FE, base);
      chk_burst("wrap", base, A, BB, C, D);
      rd(10'h000, base);
      chk_burst("wrap_low", base, C, D, '0, '0);
      wait_ready;
      base = got.size();
      br_cmd_en = 1; br_cmd = 0; br_addr = 10'h010;
      tick;
      for (int i = 1; i < L + B - 1; i++) begin
         tick;
         chk("bp_ready", 64'(cmd_ready), 64'd0);
         chk("bp_drop", 64'(cmd_dropped), 64'd1);
      end
      tick;
      br_cmd_en = 0;
      repeat (3) tick;
      chk_burst("bp", base, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      wait_ready;
      base = got.size();
      br_cmd_en = 1; br_cmd = 0; br_addr = 10'h3FE;
      tick;
      br_cmd_en = 0;
      repeat (L) tick;
      rst = 1;
      tick;
      rst = 0;
      chk("rst_valid", 64'(br_rd_data_valid), 64'd0);
      chk("rst_calib", 64'(init_calib), 64'd0);
      chk("rst_beats", 64'(got.size() - base), 64'd2);
      rd(10'h010, base);
      chk_burst("after_rst", base, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      rd(10'h020, base);
      chk("after_rst_mask", got[base], 64'hFFFF_FFFF_0000_0000);
      repeat (4) tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
